// File: rtl/uart_autobaud.sv
// Auto-baud controller: measures a 0x55 sync character on rxd and derives the
// UART prescale (clk cycles per bit), holding the last good value until re-armed.
module uart_autobaud #(
    parameter logic [15:0] DEFAULT_PRESCALE = 16'd868,
    parameter logic [15:0] MIN_PRESCALE     = 16'd8,
    parameter int          IDLE_CYCLES      = 64,
    parameter int          TIMEOUT          = 2**19
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rxd,
    input  logic        start,
    output logic [15:0] prescale,
    output logic        locked,
    output logic        done,
    output logic        error,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_HIGH,
        WAIT_FALL,
        MEASURE
    } state_t;

    localparam int              IW           = $clog2(IDLE_CYCLES + 1);
    localparam logic [IW-1:0]   IDLE_LAST    = IW'(IDLE_CYCLES - 1);
    localparam logic [19:0]     TIMEOUT_SPAN = 20'(TIMEOUT);
    localparam logic [19:0]     MIN_RESULT   = 20'(MIN_PRESCALE);

    state_t        state;
    logic          rxd_m;
    logic          rxd_s;
    logic          rxd_d;
    logic          fall;
    logic [IW-1:0] idle_cnt;
    logic [19:0]   span_cnt;
    logic [2:0]    edge_cnt;
    logic [19:0]   result;

    // NOTE: the synchronizer resets to the idle-high line level so that
    // leaving reset never manufactures a falling edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            rxd_m <= 1'b1;
            rxd_s <= 1'b1;
            rxd_d <= 1'b1;
        end else begin
            rxd_m <= rxd;
            rxd_s <= rxd_m;
            rxd_d <= rxd_s;
        end
    end

    assign fall = rxd_d & ~rxd_s;

    // Eight bit times span the 1st to 5th falling edge of 0x55; round to nearest.
    assign result = (span_cnt + 20'd4) >> 3;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            prescale <= DEFAULT_PRESCALE;
            locked   <= 1'b0;
            done     <= 1'b0;
            error    <= 1'b0;
            busy     <= 1'b0;
            idle_cnt <= '0;
            span_cnt <= '0;
            edge_cnt <= '0;
        end else begin
            done  <= 1'b0;
            error <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= WAIT_HIGH;
                        busy     <= 1'b1;
                        idle_cnt <= '0;
                    end
                end
                WAIT_HIGH: begin
                    if (rxd_s) begin
                        idle_cnt <= idle_cnt + IW'(1);
                        if (idle_cnt == IDLE_LAST) begin
                            state <= WAIT_FALL;
                        end
                    end else begin
                        idle_cnt <= '0;
                    end
                end
                WAIT_FALL: begin
                    if (fall) begin
                        state    <= MEASURE;
                        span_cnt <= 20'd1;
                        edge_cnt <= 3'd1;
                    end
                end
                MEASURE: begin
                    if (fall && edge_cnt == 3'd4) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        if (result >= MIN_RESULT && result <= 20'h0FFFF) begin
                            prescale <= result[15:0];
                            locked   <= 1'b1;
                            done     <= 1'b1;
                        end else begin
                            error <= 1'b1;
                        end
                    end else if (span_cnt >= TIMEOUT_SPAN) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        error <= 1'b1;
                    end else begin
                        span_cnt <= span_cnt + 20'd1;
                        if (fall) begin
                            edge_cnt <= edge_cnt + 3'd1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_autobaud.sv
// Self-checking bench for uart_autobaud: drives 8N1 frames with optional edge
// jitter and predicts each outcome from the recorded pin falling-edge times.
module tb_uart_autobaud;

    localparam int TIMEOUT  = 4096;
    localparam int DEF_PRE  = 868;
    localparam int MIN_PRE  = 8;
    localparam int IDLE_REQ = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic        rxd;
    logic        start;
    logic [15:0] prescale;
    logic        locked;
    logic        done;
    logic        error;
    logic        busy;

    uart_autobaud #(
        .DEFAULT_PRESCALE (16'd868),
        .MIN_PRESCALE     (16'd8),
        .IDLE_CYCLES      (IDLE_REQ),
        .TIMEOUT          (TIMEOUT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rxd      (rxd),
        .start    (start),
        .prescale (prescale),
        .locked   (locked),
        .done     (done),
        .error    (error),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int n_tests  = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int done_cnt = 0;
    int err_cnt  = 0;
    int both_cnt = 0;
    int evt_cyc  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (done) begin
            done_cnt++;
            evt_cyc = cyc;
        end
        if (error) begin
            err_cnt++;
            evt_cyc = cyc;
        end
        if (done && error) both_cnt++;
    end

    // Reference state: falling-edge times on the pin and the expected outputs.
    int falls[$];
    int exp_presc  = DEF_PRE;
    bit exp_locked = 1'b0;
    bit exp_ok;

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // 8N1 frame, LSB first; interior bit boundaries optionally moved by -1..+1 cycle.
    task automatic send_frame(input logic [7:0] data, input int bitc, input bit jit, input int nbits);
        int   s[11];
        logic [9:0] fr;
        logic prev;
        fr    = {1'b1, data, 1'b0};
        s[0]  = 0;
        s[10] = 10 * bitc;
        for (int k = 1; k < 10; k++) begin
            s[k] = k * bitc + (jit ? int'($urandom_range(2)) - 1 : 0);
        end
        prev = rxd;
        for (int k = 0; k < nbits; k++) begin
            rxd = fr[k];
            if (prev && !fr[k]) falls.push_back(cyc);
            prev = fr[k];
            tick(s[k+1] - s[k]);
        end
    endtask

    // Span from first to fifth pin fall equals the internal span; rounded divide by 8.
    task automatic run_model();
        int span;
        int res;
        exp_ok = 1'b0;
        if (falls.size() >= 5) begin
            span = falls[4] - falls[0];
            res  = (span + 4) / 8;
            if (span < TIMEOUT && res >= MIN_PRE && res <= 65535) begin
                exp_ok     = 1'b1;
                exp_presc  = res;
                exp_locked = 1'b1;
            end
        end
    endtask

    task automatic wait_outcome(input int d0, input int e0, output bit timed_out);
        timed_out = 1'b1;
        for (int i = 0; i < TIMEOUT + 3000; i++) begin
            if (done_cnt != d0 || err_cnt != e0) begin
                timed_out = 1'b0;
                break;
            end
            tick();
        end
        tick(5);
    endtask

    // Arm, idle high, send one frame, then compare the outcome with the model.
    task automatic test_frame(input string name, input logic [7:0] data, input int bitc, input bit jit);
        int d0;
        int e0;
        bit to;
        rxd = 1'b1;
        pulse_start();
        tick(100);
        falls.delete();
        d0 = done_cnt;
        e0 = err_cnt;
        send_frame(data, bitc, jit, 10);
        run_model();
        wait_outcome(d0, e0, to);
        n_tests++;
        if (to) begin
            n_fail++;
            $display("FAIL %s_wait: no done or error within cycle budget (bit=%0d)", name, bitc);
        end
        n_tests++;
        if (done_cnt - d0 !== (exp_ok ? 1 : 0)) begin
            n_fail++;
            $display("FAIL %s_done: got %0d done pulses, expected %0d (bit=%0d)", name, done_cnt - d0, exp_ok ? 1 : 0, bitc);
        end
        n_tests++;
        if (err_cnt - e0 !== (exp_ok ? 0 : 1)) begin
            n_fail++;
            $display("FAIL %s_error: got %0d error pulses, expected %0d (bit=%0d)", name, err_cnt - e0, exp_ok ? 0 : 1, bitc);
        end
        n_tests++;
        if (prescale !== 16'(exp_presc)) begin
            n_fail++;
            $display("FAIL %s_prescale: got %0d, expected %0d (bit=%0d)", name, prescale, exp_presc, bitc);
        end
        n_tests++;
        if (locked !== exp_locked || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_flags: locked=%b busy=%b, expected locked=%b busy=0", name, locked, busy, exp_locked);
        end
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        rxd   = 1'b1;
        start = 1'b0;
        tick(3);
        rst = 1'b0;
        tick();
        n_tests++;
        if (prescale !== 16'd868 || locked !== 1'b0 || done !== 1'b0 || error !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: prescale=%0d locked=%b done=%b error=%b busy=%b, expected 868/0/0/0/0",
                     prescale, locked, done, error, busy);
        end
    endtask

    task automatic test_basic();
        pulse_start();
        n_tests++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_busy_after_start: got %b, expected 1", busy);
        end
        // test_frame re-arms; the pending WAIT_HIGH ignores the second start.
        test_frame("basic16", 8'h55, 16, 1'b0);
        n_tests++;
        if (evt_cyc - falls[4] < 1 || evt_cyc - falls[4] > 4) begin
            n_fail++;
            $display("FAIL basic_latency: done %0d cycles after 5th pin fall, expected 1..4", evt_cyc - falls[4]);
        end
    endtask

    task automatic test_jitter();
        test_frame("jitter100", 8'h55, 100, 1'b1);
    endtask

    task automatic test_timeout();
        test_frame("timeout", 8'h00, 200, 1'b0);
        n_tests++;
        if (evt_cyc - falls[0] < TIMEOUT || evt_cyc - falls[0] > TIMEOUT + 6) begin
            n_fail++;
            $display("FAIL timeout_span: error %0d cycles after first fall, expected about %0d", evt_cyc - falls[0], TIMEOUT);
        end
    endtask

    task automatic test_too_fast();
        test_frame("fast4", 8'h55, 4, 1'b0);
    endtask

    task automatic test_start_ignored();
        int d0;
        int e0;
        int bitc;
        bit to;
        rxd = 1'b1;
        pulse_start();
        rxd = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick(9);
            pulse_start();
        end
        n_tests++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL ignore_busy_low: got busy=%b, expected 1", busy);
        end
        rxd = 1'b1;
        d0  = done_cnt;
        e0  = err_cnt;
        tick(40);
        pulse_start();
        tick(29);
        n_tests++;
        if (done_cnt != d0 || err_cnt != e0) begin
            n_fail++;
            $display("FAIL ignore_no_pulse: got %0d done %0d error, expected none", done_cnt - d0, err_cnt - e0);
        end
        // A restart at the start pulse above would leave too few idle cycles to catch this frame.
        bitc = $urandom_range(10, 60);
        falls.delete();
        send_frame(8'h55, bitc, 1'b0, 10);
        run_model();
        wait_outcome(d0, e0, to);
        n_tests++;
        if (to || done_cnt - d0 !== 1 || prescale !== 16'(exp_presc)) begin
            n_fail++;
            $display("FAIL ignore_then_lock: done=%0d prescale=%0d, expected done=1 prescale=%0d", done_cnt - d0, prescale, exp_presc);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 5; i++) begin
            test_frame("random", 8'h55, $urandom_range(4, 120), 1'($urandom_range(1)));
        end
    endtask

    task automatic test_reset_mid();
        rxd = 1'b1;
        pulse_start();
        tick(100);
        falls.delete();
        send_frame(8'h55, 32, 1'b0, 5);
        n_tests++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_busy_before: got %b, expected 1", busy);
        end
        rst = 1'b1;
        tick();
        n_tests++;
        if (busy !== 1'b0 || locked !== 1'b0 || prescale !== 16'd868) begin
            n_fail++;
            $display("FAIL midrst_state: busy=%b locked=%b prescale=%0d, expected 0/0/868", busy, locked, prescale);
        end
        rst        = 1'b0;
        rxd        = 1'b1;
        exp_presc  = DEF_PRE;
        exp_locked = 1'b0;
        tick(2);
        test_frame("after_rst32", 8'h55, 32, 1'b0);
    endtask

    task automatic test_exclusive();
        n_tests++;
        if (both_cnt !== 0) begin
            n_fail++;
            $display("FAIL done_error_overlap: got %0d overlapping cycles, expected 0", both_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_jitter();
        test_timeout();
        test_too_fast();
        test_start_ignored();
        test_random();
        test_reset_mid();
        test_exclusive();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, tests run %0d", n_tests);
        $fatal(1, "watchdog");
    end

endmodule
